// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader that fills instruction memory and gates the mips core reset.
// Protocol: 0x01 <cnt_hi> <cnt_lo> <4*cnt big-endian bytes> loads, 0x02 runs, 0x03 stops, 0xFF clears error.
module program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CNT_HI = 3'd1;
    localparam logic [2:0] CNT_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    logic [2:0]            state;
    logic [15:0]           count;
    logic [1:0]            byte_idx;
    logic [CW-1:0]         word_idx;
    logic [DATA_WIDTH-9:0] shreg;
    logic [DATA_WIDTH-1:0] word_next;
    logic [15:0]           cnt_full;
    logic                  xfer;
    logic                  cnt_bad;
    logic                  last_word;

    // no byte is taken in the write cycle, so the write path never competes with a transfer
    assign rx_ready  = reset && !imem_we;
    assign xfer      = rx_valid && rx_ready;
    assign word_next = {shreg, rx_data};
    assign cnt_full  = {count[15:8], rx_data};
    assign cnt_bad   = (cnt_full == 16'd0) || (cnt_full > 16'(MAX_WORDS));
    assign last_word = word_idx == CW'(count - 16'd1);
    assign cpu_reset = state != RUN;
    assign busy      = (state == CNT_HI) || (state == CNT_LO) || (state == DATA);
    assign error     = state == ERR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            shreg        <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else if (imem_we) begin
            imem_we  <= 1'b0;
            byte_idx <= 2'd0;
            word_idx <= word_idx + 1'b1;
            if (last_word) begin
                state        <= IDLE;
                words_loaded <= CW'(count);
            end
        end else if (xfer) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'h01) begin
                        state <= CNT_HI;
                    end else if (rx_data == 8'h02 && words_loaded != '0) begin
                        state <= RUN;
                    end else begin
                        state        <= ERR;
                        words_loaded <= '0;
                    end
                end
                CNT_HI: begin
                    count[15:8] <= rx_data;
                    state       <= CNT_LO;
                end
                CNT_LO: begin
                    if (cnt_bad) begin
                        state        <= ERR;
                        words_loaded <= '0;
                    end else begin
                        count[7:0] <= rx_data;
                        state      <= DATA;
                        word_idx   <= '0;
                        byte_idx   <= 2'd0;
                    end
                end
                DATA: begin
                    shreg    <= word_next[DATA_WIDTH-9:0];
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                        imem_wdata <= word_next;
                    end
                end
                RUN:     if (rx_data == 8'h03) state <= IDLE;
                ERR:     if (rx_data == 8'hFF) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed byte streams; expected imem writes go to a scoreboard checked by a monitor.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        error;
    logic [8:0]  words_loaded;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lows = 0;
    int          lows0;
    logic        streaming = 1'b0;
    logic [39:0] exp_q[$];
    logic [7:0]  txq[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
        .busy(busy), .error(error), .words_loaded(words_loaded)
    );

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [39:0] e;
        if (reset) begin
            if (streaming && !rx_ready) lows++;
            if (imem_we) begin
                chk("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", imem_addr, e[39:32]);
                    chk("wr_data", imem_wdata, e[31:0]);
                end
                chk("wr_rx_ready", rx_ready, 0);
            end
        end
    end

    // sends n bytes of v MSB-first back-to-back; returns at the negedge after the last transfer
    task automatic tx(input int n, input logic [127:0] v);
        int t;
        for (int i = n - 1; i >= 0; i--) txq.push_back(v[8*i +: 8]);
        while (txq.size() != 0) begin
            @(negedge clk);
            rx_data  = txq.pop_front();
            rx_valid = 1'b1;
            t = 0;
            while (!rx_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!rx_ready) chk("rx_ready_wait", rx_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_words"}, words_loaded, 0);
        chk({tag, "_rx_ready"}, rx_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b1;
        @(negedge clk);
        // load two words
        exp_q.push_back({8'h00, 32'h20010005});
        exp_q.push_back({8'h01, 32'h2002000A});
        tx(1, 'h01);
        chk("s1_busy_cnt", busy, 1);
        chk("s1_cpu_reset_a", cpu_reset, 1);
        tx(6, 'h0002_2001_0005);
        chk("s1_busy_w0", busy, 1);
        chk("s1_words_mid", words_loaded, 0);
        tx(4, 'h2002000A);
        @(negedge clk);
        chk("s1_busy_done", busy, 0);
        chk("s1_words", words_loaded, 2);
        chk("s1_cpu_reset_b", cpu_reset, 1);
        chk("s1_q_empty", exp_q.size(), 0);
        // run / stop / run
        tx(1, 'h02);
        chk("s2_run", cpu_reset, 0);
        tx(1, 'h55);
        chk("s2_run_discard", cpu_reset, 0);
        tx(1, 'h03);
        chk("s2_stop", cpu_reset, 1);
        chk("s2_stop_busy", busy, 0);
        tx(1, 'h02);
        chk("s2_rerun", cpu_reset, 0);
        chk("s2_rerun_words", words_loaded, 2);
        tx(1, 'h03);
        chk("s2_stop2", cpu_reset, 1);
        // run with nothing loaded
        pulse_reset();
        tx(1, 'h02);
        chk("s3_err", error, 1);
        chk("s3_cpu_reset", cpu_reset, 1);
        tx(1, 'h55);
        chk("s3_err_hold", error, 1);
        tx(1, 'hFF);
        chk("s3_clear", error, 0);
        chk("s3_busy", busy, 0);
        // count boundaries
        tx(3, 'h010000);
        chk("s4_cnt0", error, 1);
        tx(1, 'hFF);
        exp_q.push_back({8'h00, 32'hDEADBEEF});
        tx(7, 'h010001_DEADBEEF);
        @(negedge clk);
        chk("s4_words1", words_loaded, 1);
        tx(3, 'h010101);
        chk("s4_cnt257", error, 1);
        chk("s4_words_clr", words_loaded, 0);
        tx(1, 'hFF);
        tx(3, 'h010100);
        chk("s4_cnt256_err", error, 0);
        chk("s4_cnt256_busy", busy, 1);
        // reset mid-load
        pulse_reset();
        exp_q.push_back({8'h00, 32'h11223344});
        tx(9, 'h010003_112233445566);
        chk("s5_hold_wdata", imem_wdata, 32'h11223344);
        chk("s5_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_state("s5");
        @(negedge clk);
        reset = 1'b1;
        tx(1, 'h02);
        chk("s5_run_err", error, 1);
        tx(1, 'hFF);
        // back-to-back three-word load
        exp_q.push_back({8'h00, 32'hA1A2A3A4});
        exp_q.push_back({8'h01, 32'hB1B2B3B4});
        exp_q.push_back({8'h02, 32'hC1C2C3C4});
        lows0 = lows;
        streaming = 1'b1;
        tx(15, 'h010003_A1A2A3A4_B1B2B3B4_C1C2C3C4);
        @(negedge clk);
        streaming = 1'b0;
        chk("s6_ready_lows", lows - lows0, 3);
        chk("s6_words", words_loaded, 3);
        chk("s6_busy", busy, 0);
        chk("final_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot/debug front-end that sits directly upstream of the mips core.
- Receives a byte stream over a valid/ready link and assembles big-endian 32-bit words.
- Writes those words into instruction memory, then holds the core in reset or releases it on command.
- Replaces the hard-coded program image so the pipeline can be loaded and restarted at run time.

Parameters:
DATA_WIDTH, 32, instruction word width (must be 32)
ADDR_WIDTH, 8, instruction memory word-address width
MAX_WORDS, 256, largest legal load count (must be ≤ 2**ADDR_WIDTH)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address of write
imem_wdata  output  DATA_WIDTH  word to write
cpu_reset  output  1  active-high reset driven to mips core
busy  output  1  high in CNT_HI, CNT_LO, DATA
error  output  1  high in ERR
words_loaded  output  ADDR_WIDTH+1  count of last completed load

Behaviour:
- Byte transfer occurs on a rising edge when rx_valid && rx_ready. rx_valid held without rx_ready is not a transfer. rx_ready is combinationally 1 in every state except the cycle imem_we is high; it is 0 during reset.
- Reset (reset=0, asynchronous) sets:
  - state=IDLE
  - cpu_reset=1
  - imem_we=0, imem_addr=0, imem_wdata=0
  - busy=0, error=0, words_loaded=0
  - internal count, byte index and word index cleared.
- Reset mid-load abandons the load. Words already written stay in memory; words_loaded=0.
- States and transitions:
  - IDLE (cpu_reset=1):
    - 0x01 -> CNT_HI.
    - 0x02 -> RUN if words_loaded≠0, else ERR.
    - any other byte -> ERR.
  - CNT_HI: byte -> count[15:8] -> CNT_LO.
  - CNT_LO: byte -> count[7:0].
    - If count==0 or count>MAX_WORDS -> ERR.
    - Else -> DATA with word_idx=0, byte_idx=0.
  - DATA: each byte shifts into the assembly register MSB first (first byte = bits 31:24).
    - On the 4th byte, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr=word_idx and imem_wdata=assembled word.
    - In that write cycle rx_ready=0, word_idx increments and byte_idx returns to 0.
    - Write cycle of word count-1: the following state is IDLE and words_loaded=count.
    - Minimum per-word cost: 4 transfer cycles + 1 write cycle.
  - RUN: cpu_reset=0 from the first cycle in RUN (registered, one cycle after the 0x02 transfer).
    - 0x03 -> IDLE with cpu_reset=1 the next cycle.
    - All other bytes are accepted and discarded.
  - ERR: error=1, cpu_reset=1, words_loaded=0.
    - 0xFF -> IDLE with error=0.
    - Other bytes are accepted and discarded.
- imem_addr and imem_wdata hold their last written values when imem_we=0.
- cpu_reset is never 0 outside RUN.
- word_idx never exceeds count-1, so no wrap-around of imem_addr.
- Counts wider than ADDR_WIDTH+1 are impossible because of the MAX_WORDS check.
- Unused count bits are ignored only for the comparison width; the full 16 bits are compared.

Test Plan:
1. Reset, then stream 01 00 02 20 01 00 05 20 02 00 0A -> imem_we pulses twice: (addr 0, 0x20010005) and (addr 1, 0x2002000A); words_loaded=2; busy high from the first count byte until the second write; cpu_reset stays 1.
2. After scenario 1, send 02 -> cpu_reset=0 one cycle later and the core executes. Send 03 -> cpu_reset=1 and state IDLE. A second 02 runs again with words_loaded still 2.
3. From reset send 02 (nothing loaded) -> error=1, cpu_reset=1. Send 55 -> still error. Send FF -> error=0, IDLE.
4. Send 01 00 00 -> ERR. Send 01 01 01 with MAX_WORDS=256 -> ERR, words_loaded=0.
5. Pull reset low after 01 00 03 plus 6 data bytes (one word written) -> all outputs at reset values immediately; memory word 0 retains its value; the next 02 -> ERR.
6. Assert rx_valid continuously with back-to-back bytes during a 3-word load -> rx_ready drops exactly in each of the 3 write cycles; no byte is lost or duplicated; written words match the stream.
